uart_rx: RTL and testbench

//   8N1 UART receiver; the receive-side counterpart of the team's UART_tx.

---
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised RX, mid-bit sampling with a down-counting
// baud timer, sticky rdy flag and framing-error flag for the command layer.
module uart_rx #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_sync1;
  logic             r_rx_s;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_cnt;   // bit 3 is the terminal flag; the count never wraps
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_rdy;
  logic             r_frm_err;

  logic w_fall;
  logic w_sample;
  logic w_detect;
  logic w_reload;
  logic w_shift;
  logic w_finish;

  // Sync flops reset high so releasing reset with an idle line is not a start edge.
  // A third flop keeps the previous rx_s so IDLE re-arms only on a 1->0 transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make this a true shift chain, not one flop.
      r_sync1   <= RX;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall   = r_rx_prev & ~r_rx_s;
  assign w_sample = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next_state = START;
      START: if (w_sample) w_next_state = r_rx_s ? IDLE : DATA;
      DATA:  if (w_sample && r_bit_cnt == 4'd7) w_next_state = STOP;
      STOP:  if (w_sample) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_detect = 1'b0;
    w_reload = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE:  w_detect = w_fall;
      START: w_reload = w_sample;
      DATA: begin
        w_shift  = w_sample & ~r_bit_cnt[3];
        w_reload = w_sample;
      end
      STOP:  w_finish = w_sample;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_rdy     <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      if (w_detect)      r_cnt <= HALF_BIT;
      else if (w_reload) r_cnt <= FULL_M1;
      else if (!w_sample) r_cnt <= r_cnt - 1'b1;

      if (w_detect) r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 4'd1;

      if (w_shift) r_shift <= {r_rx_s, r_shift[7:1]};

      if (w_finish) begin
        r_rx_data <= r_shift;
        r_frm_err <= ~r_rx_s;
      end

      // A completing frame outranks a same-cycle clear.
      if (w_finish)                r_rdy <= 1'b1;
      else if (clr_rdy || w_detect) r_rdy <= 1'b0;
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: bit-banged 8N1 frames against a queue of expected bytes,
// with a monitor that checks every rdy rising edge.
module tb_uart_rx;

  localparam int D = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   rise_cyc = 0;
  logic prev_rdy = 1'b0;

  uart_rx #(.BAUD_DIV(D), .CNT_W(12)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  // Each completed frame must match the oldest byte the bench transmitted.
  always @(negedge clk) begin
    if (rst_n && rdy && !prev_rdy) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
      if (exp_q.size() == 0) begin
        check("extra_frame", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
        check("frm_err", {31'd0, frm_err}, {31'd0, mon_e.ferr});
      end
    end
    prev_rdy <= rdy;
  end

  task automatic bit_time(input logic v);
    RX = v;
    repeat (D) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    exp_q.push_back('{data: b, ferr: ~stop_v});
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_v);
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int k = 0;
    while (rise_cnt < target && k < 4 * D) begin
      @(negedge clk);
      k++;
    end
    check("frame_count", rise_cnt, target);
  endtask

  initial begin
    int start_cyc;
    int lat;
    logic [7:0] b;
    int gap;

    RX = 1'b1;
    clr_rdy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {31'd0, rdy}, 0);
    check("reset_data", {24'd0, rx_data}, 0);
    check("reset_ferr", {31'd0, frm_err}, 0);
    rst_n = 1'b1;
    idle(2 * D);

    // Single good frame and its latency from the falling edge.
    start_cyc = cyc;
    send_frame(8'hA5, 1'b1);
    wait_frames(1);
    lat = rise_cyc - start_cyc;
    check("latency_window", {31'd0, (lat >= 9 * D + D / 2) && (lat <= 9 * D + D / 2 + 6)}, 1);
    idle(D);
    check("rdy_sticky", {31'd0, rdy}, 1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_frames(3);
    check("b2b_rdy", {31'd0, rdy}, 1);
    check("b2b_data", {24'd0, rx_data}, 32'hFF);

    // Short glitch is rejected as a false start.
    pulse_clr();
    check("clr_rdy", {31'd0, rdy}, 0);
    RX = 1'b0;
    repeat (D / 2 - 6) @(posedge clk);
    #1;
    idle(2 * D);
    check("glitch_rdy", {31'd0, rdy}, 0);
    check("glitch_data", {24'd0, rx_data}, 32'hFF);
    check("glitch_frames", rise_cnt, 3);

    // Framing error, then a good frame clears it.
    send_frame(8'h3C, 1'b0);
    idle(D);
    wait_frames(4);
    check("ferr_set", {31'd0, frm_err}, 1);
    send_frame(8'hC3, 1'b1);
    wait_frames(5);
    check("ferr_clear", {31'd0, frm_err}, 0);

    // clr_rdy active in the cycle rdy sets: set wins.
    clr_rdy = 1'b1;
    fork
      send_frame(8'h96, 1'b1);
      begin
        int k = 0;
        while (!rdy && k < 12 * D) begin
          @(negedge clk);
          k++;
        end
        clr_rdy = 1'b0;
        check("set_wins_seen", {31'd0, rdy}, 1);
      end
    join
    wait_frames(6);
    check("set_wins_hold", {31'd0, rdy}, 1);
    pulse_clr();
    check("clr_next_cycle", {31'd0, rdy}, 0);

    // Reset during bit 4 aborts the frame.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    RX = 1'b1;
    repeat (D / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_data", {24'd0, rx_data}, 0);
    check("midrst_rdy", {31'd0, rdy}, 0);
    check("midrst_ferr", {31'd0, frm_err}, 0);
    RX = 1'b1;
    rst_n = 1'b1;
    idle(2 * D);
    check("midrst_noframe", rise_cnt, 6);
    send_frame(8'h5A, 1'b1);
    wait_frames(7);

    // Line held low: one all-zero frame with framing error, then no re-detect.
    exp_q.push_back('{data: 8'h00, ferr: 1'b1});
    RX = 1'b0;
    repeat (12 * D) @(posedge clk);
    #1;
    wait_frames(8);
    pulse_clr();
    repeat (3 * D) @(posedge clk);
    #1;
    check("break_rdy", {31'd0, rdy}, 0);
    check("break_frames", rise_cnt, 8);
    idle(2 * D);

    // Random bytes with random gaps, including zero.
    for (int n = 0; n < 8; n++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, D);
      send_frame(b, 1'b1);
      idle(gap);
    end
    wait_frames(16);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
